// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the 5-stage core's pipeline and its hazard controller.
// The pipeline (master) supplies register/control fields; the controller (slave) returns stall/flush/forward.
interface hazard_ctrl_if #(
  parameter int N     = 5,
  parameter int CNT_W = 16
);
  logic [N-1:0]     rsD, rtD, rsE, rtE;
  logic [N-1:0]     WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemToRegE, MemToRegM;
  logic             BranchD, BranchTakenD, JumpD;
  logic             MduStartE, MduReadD;
  logic             StallF, StallD, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD;
  logic             MduBusy;
  logic [CNT_W-1:0] StallCnt;

  modport master (
    output rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM,
           BranchD, BranchTakenD, JumpD, MduStartE, MduReadD,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           ForwardAD, ForwardBD, MduBusy, StallCnt
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW,
           RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM,
           BranchD, BranchTakenD, JumpD, MduStartE, MduReadD,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
           ForwardAD, ForwardBD, MduBusy, StallCnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: combinational forwarding and stall detection,
// an INIT/RUN/MDU FSM tracking the multi-cycle MDU, and a saturating stall counter.
module hazard_ctrl #(
  parameter int N       = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic          CLK,
  input  logic          CLR,
  hazard_ctrl_if.slave  hz
);
  localparam int CW = ($clog2(MDU_LAT + 1) < 3) ? 3 : $clog2(MDU_LAT + 1);

  typedef enum logic [1:0] {INIT, RUN, MDU} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lwstall, brstall, mdustall, stall;

  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic hit(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    lwstall  = hz.MemToRegE && (hit(hz.WriteRegE, hz.rsD) || hit(hz.WriteRegE, hz.rtD));
    brstall  = hz.BranchD &&
               ((hz.RegWriteE && (hit(hz.WriteRegE, hz.rsD) || hit(hz.WriteRegE, hz.rtD))) ||
                (hz.MemToRegM && (hit(hz.WriteRegM, hz.rsD) || hit(hz.WriteRegM, hz.rtD))));
    mdustall = (state == MDU) && hz.MduReadD;
    stall    = lwstall || brstall || mdustall;
  end

  always_comb begin
    hz.ForwardAE = 2'b00;
    if (hz.RegWriteM && hit(hz.WriteRegM, hz.rsE))      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && hit(hz.WriteRegW, hz.rsE)) hz.ForwardAE = 2'b01;
    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && hit(hz.WriteRegM, hz.rtE))      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && hit(hz.WriteRegW, hz.rtE)) hz.ForwardBE = 2'b01;
    hz.ForwardAD = hz.RegWriteM && hit(hz.WriteRegM, hz.rsD);
    hz.ForwardBD = hz.RegWriteM && hit(hz.WriteRegM, hz.rtD);
  end

  // A stall holds the branch in Decode, so it must not be flushed; it re-resolves next cycle.
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.FlushD = 1'b1;
    hz.FlushE = 1'b1;
    if (state != INIT) begin
      hz.StallF = stall;
      hz.StallD = stall;
      hz.FlushE = stall;
      hz.FlushD = (hz.BranchTakenD || hz.JumpD) && !stall;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: state_nxt = RUN;
      RUN: if (hz.MduStartE) begin
        state_nxt = MDU;
        cnt_nxt   = CW'(MDU_LAT);
      end
      MDU: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) state_nxt = RUN;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= INIT;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if ((state != INIT) && stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz.MduBusy  = (state == MDU);
  assign hz.StallCnt = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for forwarding/stall/flush, plus
// hand sequences for reset, MDU timing, reset mid-MDU and counter saturation.
module tb_hazard_ctrl;
  localparam int N = 5, MDU_LAT = 4, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK, CLR;
  int   checks = 0, errors = 0;
  int   exp_cnt = 0;

  hazard_ctrl_if #(.N(N), .CNT_W(CNT_W)) hz ();
  hazard_ctrl #(.N(N), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (.CLK(CLK), .CLR(CLR), .hz(hz));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Starting an MDU op while the MDU is busy is a pipeline protocol error.
  assert property (@(posedge CLK) disable iff (CLR) !(hz.MduStartE && hz.MduBusy));

  typedef struct {
    logic [N-1:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic rwE, rwM, rwW, m2rE, m2rM, brD, btD, jD;
    logic e_st, e_fD;
    logic [1:0] e_fAE, e_fBE;
    logic e_fAD, e_fBD;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
    hz.WriteRegE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
    hz.RegWriteE = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.MemToRegE = 0; hz.MemToRegM = 0;
    hz.BranchD = 0; hz.BranchTakenD = 0; hz.JumpD = 0;
    hz.MduStartE = 0; hz.MduReadD = 0;
  endtask

  task automatic set_lw();
    hz.MemToRegE = 1; hz.WriteRegE = 5'd8; hz.rsD = 5'd8;
  endtask

  // Reference counter: saturating tally of stalled cycles outside INIT.
  task automatic cnt_step(input logic st);
    if (st && exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  initial begin
    vt[0]  = '{m2rE:1, rwM:1, default:'0};
    vt[1]  = '{m2rE:1, wE:8, rsD:8, e_st:1, default:'0};
    vt[2]  = '{m2rE:1, wE:9, rtD:9, rsD:8, e_st:1, default:'0};
    vt[3]  = '{rwM:1, rwW:1, wM:5, wW:5, rsE:5, rsD:5, e_fAE:2'b10, e_fAD:1, default:'0};
    vt[4]  = '{rwW:1, wW:5, rsE:5, rtE:5, e_fAE:2'b01, e_fBE:2'b01, default:'0};
    vt[5]  = '{rwM:1, wM:7, rtE:7, rtD:7, rwW:1, wW:6, rsE:6,
               e_fAE:2'b01, e_fBE:2'b10, e_fBD:1, default:'0};
    vt[6]  = '{brD:1, btD:1, rsD:3, rtD:4, e_fD:1, default:'0};
    vt[7]  = '{brD:1, btD:1, rwE:1, wE:3, rsD:3, e_st:1, default:'0};
    vt[8]  = '{brD:1, m2rM:1, rwM:1, wM:4, rtD:4, e_st:1, e_fBD:1, default:'0};
    vt[9]  = '{rwE:1, wE:3, rsD:3, default:'0};
    vt[10] = '{jD:1, e_fD:1, default:'0};
    vt[11] = '{jD:1, m2rE:1, wE:2, rsD:2, e_st:1, default:'0};

    clr_in();
    CLR = 1'b1;
    #12;
    chk("rst_flushD", hz.FlushD, 1);
    chk("rst_flushE", hz.FlushE, 1);
    chk("rst_stallF", hz.StallF, 0);
    chk("rst_cnt", hz.StallCnt, 0);
    chk("rst_busy", hz.MduBusy, 0);

    @(negedge CLK); CLR = 1'b0;
    #1;
    chk("init_flushD", hz.FlushD, 1);
    chk("init_flushE", hz.FlushE, 1);
    @(posedge CLK); #1;
    chk("run_flushD", hz.FlushD, 0);
    chk("run_flushE", hz.FlushE, 0);
    chk("run_cnt", hz.StallCnt, 0);

    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      clr_in();
      hz.rsD = vt[i].rsD; hz.rtD = vt[i].rtD; hz.rsE = vt[i].rsE; hz.rtE = vt[i].rtE;
      hz.WriteRegE = vt[i].wE; hz.WriteRegM = vt[i].wM; hz.WriteRegW = vt[i].wW;
      hz.RegWriteE = vt[i].rwE; hz.RegWriteM = vt[i].rwM; hz.RegWriteW = vt[i].rwW;
      hz.MemToRegE = vt[i].m2rE; hz.MemToRegM = vt[i].m2rM;
      hz.BranchD = vt[i].brD; hz.BranchTakenD = vt[i].btD; hz.JumpD = vt[i].jD;
      #1;
      chk($sformatf("v%0d_stallF", i), hz.StallF, vt[i].e_st);
      chk($sformatf("v%0d_stallD", i), hz.StallD, vt[i].e_st);
      chk($sformatf("v%0d_flushE", i), hz.FlushE, vt[i].e_st);
      chk($sformatf("v%0d_flushD", i), hz.FlushD, vt[i].e_fD);
      chk($sformatf("v%0d_fAE", i), hz.ForwardAE, vt[i].e_fAE);
      chk($sformatf("v%0d_fBE", i), hz.ForwardBE, vt[i].e_fBE);
      chk($sformatf("v%0d_fAD", i), hz.ForwardAD, vt[i].e_fAD);
      chk($sformatf("v%0d_fBD", i), hz.ForwardBD, vt[i].e_fBD);
      cnt_step(vt[i].e_st);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_cnt", i), hz.StallCnt, exp_cnt);
    end

    // MDU start coinciding with a load-use stall still launches the MDU.
    @(negedge CLK);
    clr_in(); set_lw();
    hz.MduStartE = 1; hz.MduReadD = 1;
    #1;
    chk("mdu_start_busy", hz.MduBusy, 0);
    chk("mdu_start_stall", hz.StallF, 1);
    cnt_step(1'b1);
    for (int k = 0; k < MDU_LAT; k++) begin
      @(negedge CLK);
      clr_in(); hz.MduReadD = 1;
      #1;
      chk($sformatf("mdu%0d_busy", k), hz.MduBusy, 1);
      chk($sformatf("mdu%0d_stall", k), hz.StallD, 1);
      chk($sformatf("mdu%0d_flushE", k), hz.FlushE, 1);
      cnt_step(1'b1);
    end
    @(negedge CLK); #1;
    chk("mdu_end_busy", hz.MduBusy, 0);
    chk("mdu_end_stall", hz.StallF, 0);
    chk("mdu_cnt", hz.StallCnt, exp_cnt);

    // Reset while the MDU counter sits at 2.
    clr_in(); hz.MduStartE = 1;
    @(negedge CLK); clr_in();
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("mid_busy_pre", hz.MduBusy, 1);
    CLR = 1'b1;
    #1;
    chk("mid_busy_rst", hz.MduBusy, 0);
    chk("mid_flushD", hz.FlushD, 1);
    chk("mid_flushE", hz.FlushE, 1);
    chk("mid_cnt", hz.StallCnt, 0);
    exp_cnt = 0;
    @(negedge CLK); CLR = 1'b0;
    #1;
    chk("mid_init_flushD", hz.FlushD, 1);
    @(posedge CLK); #1;
    chk("mid_run_flushD", hz.FlushD, 0);
    chk("mid_run_busy", hz.MduBusy, 0);

    // Continuous stall drives the counter into saturation and holds it there.
    @(negedge CLK); clr_in(); set_lw();
    for (int k = 0; k < CNT_MAX + 5; k++) begin
      cnt_step(1'b1);
      @(posedge CLK); #1;
      chk($sformatf("sat%0d_cnt", k), hz.StallCnt, exp_cnt);
    end
    chk("sat_final", hz.StallCnt, CNT_MAX);

    @(negedge CLK); clr_in();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
